riscv_exec_unit: RTL and testbench
==================================

Name: riscv_exec_unit

Overview:
Parametrised RV32I/RV64I integer execute stage; successor to the single-opcode ALU.
- Covers LUI, AUIPC, all OP and OP-IMM ALU ops.
- Valid/ready handshakes on input and output, with a registered result.
- Optional multi-cycle serial shifter for area-constrained builds.
- Sits between decode (supplies decoded imm, pc, operands) and writeback.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
SERIAL_SHIFT, 0, 0 = single-cycle barrel shifts; 1 = shifts iterate one bit per cycle.

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  unit accepts operation this cycle
opcode  input  7  instruction opcode
funct3  input  3  instruction funct3
funct7  input  7  instruction funct7 (OP-IMM shifts: imm[11:5] copy)
imm  input  XLEN  decoded, sign-extended immediate (U-type already shifted left by 12)
pc  input  XLEN  instruction address (AUIPC)
rs1  input  XLEN  source operand 1
rs2  input  XLEN  source operand 2
out_valid  output  1  result available
out_ready  input  1  writeback consumes result
rd  output  XLEN  result
out_illegal  output  1  accepted op was unsupported; qualified by out_valid

Behaviour:
- Handshake and output register:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - out_valid, rd and out_illegal are held stable while out_valid && !out_ready.
  - out_valid falls the cycle after out_ready is seen, unless a new result is loaded in the same cycle.
- Reset: state=IDLE, out_valid=0, rd=0, out_illegal=0, shift counter=0. Reset during SHIFT abandons the op and produces no result.
- Operand 2: rs2 for OP; imm for OP-IMM. Shift amount shamt = operand2[$clog2(XLEN)-1:0].
- Operations:
  - LUI: rd = imm.
  - AUIPC: rd = pc + imm.
  - ADD/ADDI, SUB (funct7=0100000, OP only), XOR, OR, AND and immediate forms.
  - SLT/SLTI signed, SLTU/SLTIU unsigned; result is 0 or 1, zero-extended.
  - SLL, SRL, SRA (funct7=0100000); SRA sign-fills.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
- Illegal cases: any other opcode/funct combination, including OP-32/OP-IMM-32 when XLEN=64, completes in 1 cycle with rd=0 and out_illegal=1.
- Latency, non-shift or SERIAL_SHIFT=0: result registered 1 cycle after accept.
- SERIAL_SHIFT=1 state machine, IDLE -> SHIFT -> IDLE:
  - Shift with shamt=0: completes like a non-shift op (rd=rs1, 1 cycle).
  - Shift with shamt=N>0: latch operand, counter=N, enter SHIFT.
  - Each SHIFT cycle shifts by 1 bit and decrements the counter.
  - When counter reaches 0: load rd, set out_valid, return to IDLE. Latency is N cycles.
  - in_ready=0 throughout SHIFT.
- Simultaneous out_ready and accept in IDLE: the old result retires and the new result loads the next cycle with no bubble.

Optional Feature:
RISCV_EXEC_MUL_EN
- Defined: OP with funct7=0000001 and funct3 000/001/010/011 executes MUL/MULH/MULHSU/MULHU.
  - Full 2*XLEN product; low or high half selected per funct3.
  - Signedness per RISC-V M spec; 1-cycle latency.
  - funct3 1xx (divide/remainder) is flagged illegal.
- Undefined: every funct7=0000001 OP encoding is flagged illegal; no multiplier is synthesised.

Decomposition:
- Package riscv_exec_pkg holds:
  - opcode constants (OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM);
  - funct3 constants (F3_ADD, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SR, F3_OR, F3_AND);
  - funct7 constants (F7_BASE, F7_ALT, F7_MULDIV);
  - state enum exec_state_t {IDLE, SHIFT}.
- Sub-module riscv_alu: purely combinational op decode plus result and illegal flag. The top owns the handshake, serial shifter FSM and output register.

Test Plan:
1. XLEN=32, OP ADD rs1=0x7FFFFFFF rs2=1 -> rd=0x80000000 one cycle later, out_illegal=0. SUB 0 - 1 -> 0xFFFFFFFF.
2. SLT rs1=0xFFFFFFFF rs2=1 -> rd=1. SLTU with the same operands -> rd=0. SRAI rs1=0x80000000 shamt=4 -> 0xF8000000.
3. SERIAL_SHIFT=1, SLL rs1=1 shamt=31 -> in_ready low 31 cycles, rd=0x80000000 exactly 31 cycles after accept. Reset asserted at cycle 10 -> out_valid stays 0, in_ready=1 after reset.
4. Backpressure: out_ready=0 for 5 cycles after ADD completes -> rd held, in_ready=0. Raise out_ready with in_valid high -> next result follows with no bubble.
5. Illegal opcode 0x7F, and (XLEN=64) OP-32 ADDW -> rd=0, out_illegal=1, 1-cycle latency. XLEN=64 AUIPC pc=0x1000 imm=0xFFFFFFFFFFFFF000 -> rd=0.
6. RISCV_EXEC_MUL_EN defined: MULH 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000000; MULHU -> 0xFFFFFFFE; DIV -> illegal. Undefined: MUL -> out_illegal=1.

Source files
------------

// File: rtl/riscv_exec_pkg.sv
// rtl/riscv_exec_pkg.sv - shared encodings for the riscv_exec_unit slice
// Purpose: opcode/funct3/funct7 constants, FSM state type and serial shift kinds.
// Ports: none (package).
package riscv_exec_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic {IDLE, SHIFT} exec_state_t;

  // Direction/fill of a shift, handed from the decoder to the serial shifter.
  localparam logic [1:0] SH_LL = 2'd0;
  localparam logic [1:0] SH_RL = 2'd1;
  localparam logic [1:0] SH_RA = 2'd2;

endpackage

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - combinational decode and result for LUI/AUIPC/OP/OP-IMM
// Purpose: decodes one operation and produces its result and illegal flag.
// Optional feature macro: RISCV_EXEC_MUL_EN (adds MUL/MULH/MULHSU/MULHU).
// Ports:
//   opcode, funct3, funct7  - instruction fields
//   imm, pc, rs1, rs2       - decoded immediate, instruction address, operands
//   result                  - operation result (0 when illegal)
//   illegal                 - encoding not supported
//   is_shift, shift_kind    - legal shift and its kind, for the serial shifter
//   shamt                   - shift amount taken from operand 2
module riscv_alu
  import riscv_exec_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int SERIAL_SHIFT = 0
) (
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic [XLEN-1:0]         imm,
  input  logic [XLEN-1:0]         pc,
  input  logic [XLEN-1:0]         rs1,
  input  logic [XLEN-1:0]         rs2,
  output logic [XLEN-1:0]         result,
  output logic                    illegal,
  output logic                    is_shift,
  output logic [1:0]              shift_kind,
  output logic [$clog2(XLEN)-1:0] shamt
);

  localparam bit WIDE = (XLEN == 64);

  logic            is_op;
  logic [XLEN-1:0] op2;
  logic [6:0]      f7_shift;
  logic [XLEN-1:0] shl, shr, sha;

  assign is_op = (opcode == OPC_OP);
  assign op2   = is_op ? rs2 : imm;
  assign shamt = op2[$clog2(XLEN)-1:0];
  // On RV64 OP-IMM, funct7[0] is shamt[5], so only imm[11:6] selects the shift.
  assign f7_shift = (is_op || !WIDE) ? funct7 : {funct7[6:1], 1'b0};

  // A serial build iterates shifts in the top; here only shamt==0 reaches
  // the result, where the shift is the identity, so no barrel is built.
  if (SERIAL_SHIFT != 0) begin : g_serial
    assign shl = rs1;
    assign shr = rs1;
    assign sha = rs1;
  end else begin : g_barrel
    assign shl = rs1 << shamt;
    assign shr = rs1 >> shamt;
    assign sha = $signed(rs1) >>> shamt;
  end

`ifdef RISCV_EXEC_MUL_EN
  // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
  logic              a_signed, b_signed;
  logic [2*XLEN-1:0] ma, mb, prod;
  assign a_signed = funct3[0] ^ funct3[1];
  assign b_signed = (funct3 == 3'b001);
  assign ma   = {{XLEN{a_signed & rs1[XLEN-1]}}, rs1};
  assign mb   = {{XLEN{b_signed & rs2[XLEN-1]}}, rs2};
  assign prod = ma * mb;
`endif

  always_comb begin
    result     = '0;
    illegal    = 1'b0;
    is_shift   = 1'b0;
    shift_kind = SH_LL;
    case (opcode)
      OPC_LUI:   result = imm;
      OPC_AUIPC: result = pc + imm;
      OPC_OP, OPC_OP_IMM: begin
        if (is_op && funct7 == F7_MULDIV) begin
`ifdef RISCV_EXEC_MUL_EN
          if (funct3[2]) illegal = 1'b1;
          else result = (funct3 == F3_ADD) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`else
          illegal = 1'b1;
`endif
        end else if (is_op && funct7 != F7_BASE &&
                     !(funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR))) begin
          illegal = 1'b1;
        end else begin
          case (funct3)
            F3_ADD:  result = (is_op && funct7 == F7_ALT) ? rs1 - op2 : rs1 + op2;
            F3_SLL: begin
              if (f7_shift != F7_BASE) illegal = 1'b1;
              else begin
                is_shift   = 1'b1;
                shift_kind = SH_LL;
                result     = shl;
              end
            end
            F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(op2))};
            F3_SLTU: result = {{(XLEN-1){1'b0}}, (rs1 < op2)};
            F3_XOR:  result = rs1 ^ op2;
            F3_SR: begin
              if (f7_shift == F7_BASE) begin
                is_shift   = 1'b1;
                shift_kind = SH_RL;
                result     = shr;
              end else if (f7_shift == F7_ALT) begin
                is_shift   = 1'b1;
                shift_kind = SH_RA;
                result     = sha;
              end else begin
                illegal = 1'b1;
              end
            end
            F3_OR:   result = rs1 | op2;
            default: result = rs1 & op2;
          endcase
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_exec_unit.sv
// rtl/riscv_exec_unit.sv - RV32I/RV64I integer execute stage with handshakes
// Purpose: accepts decoded ops, computes via riscv_alu (or the serial shifter
// when SERIAL_SHIFT=1) and holds the result in an output register.
// Optional feature macro: RISCV_EXEC_MUL_EN (passed through to riscv_alu).
// Ports:
//   clock, reset                  - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready           - operation handshake
//   opcode, funct3, funct7        - instruction fields
//   imm, pc, rs1, rs2             - decoded immediate, address, operands
//   out_valid / out_ready         - result handshake
//   rd, out_illegal               - result and unsupported-op flag
module riscv_exec_unit
  import riscv_exec_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int SERIAL_SHIFT = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            out_illegal
);

  localparam int SW = $clog2(XLEN);

  exec_state_t     state;
  logic [SW-1:0]   cnt;
  logic [XLEN-1:0] shreg;
  logic [1:0]      kind;
  logic [XLEN-1:0] step;

  logic [XLEN-1:0] alu_result;
  logic            alu_illegal;
  logic            alu_is_shift;
  logic [1:0]      alu_kind;
  logic [SW-1:0]   alu_shamt;
  logic            accept;
  logic            go_serial;

  riscv_alu #(.XLEN(XLEN), .SERIAL_SHIFT(SERIAL_SHIFT)) u_alu (
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .pc         (pc),
    .rs1        (rs1),
    .rs2        (rs2),
    .result     (alu_result),
    .illegal    (alu_illegal),
    .is_shift   (alu_is_shift),
    .shift_kind (alu_kind),
    .shamt      (alu_shamt)
  );

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign go_serial = (SERIAL_SHIFT != 0) && alu_is_shift && (alu_shamt != '0);

  // One-bit step of the serial shifter.
  always_comb begin
    step = {1'b0, shreg[XLEN-1:1]};
    case (kind)
      SH_LL:   step = {shreg[XLEN-2:0], 1'b0};
      SH_RA:   step = {shreg[XLEN-1], shreg[XLEN-1:1]};
      default: step = {1'b0, shreg[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      rd          <= '0;
      out_illegal <= 1'b0;
      cnt         <= '0;
      shreg       <= '0;
      kind        <= SH_LL;
    end else begin
      // Retire first; a result loaded below in the same cycle overrides it.
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (go_serial) begin
              shreg <= rs1;
              cnt   <= alu_shamt;
              kind  <= alu_kind;
              state <= SHIFT;
            end else begin
              rd          <= alu_result;
              out_illegal <= alu_illegal;
              out_valid   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          shreg <= step;
          cnt   <= cnt - 1'b1;
          if (cnt == SW'(1)) begin
            rd          <= step;
            out_illegal <= 1'b0;
            out_valid   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_exec_unit.sv
// tb/tb_riscv_exec_unit.sv - self-checking bench for riscv_exec_unit (XLEN=32, serial shifts)
module tb_riscv_exec_unit;
  import riscv_exec_pkg::*;

  localparam int XLEN = 32;
  localparam int SER  = 1;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm, pc, rs1, rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rd;
  logic            out_illegal;

  riscv_exec_unit #(.XLEN(XLEN), .SERIAL_SHIFT(SER)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .imm         (imm),
    .pc          (pc),
    .rs1         (rs1),
    .rs2         (rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rd          (rd),
    .out_illegal (out_illegal)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit rand_ready = 0;

  typedef struct {
    logic [31:0] r;
    logic        ill;
    int          due;
    bit          seen;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: result, illegal flag and number of serial shift cycles.
  function automatic void model(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] im, input logic [31:0] p,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic il, output int extra);
    logic [31:0] o2;
    int          sh;
    logic [63:0] pr;
    longint      sa, sb;
    r = 0; il = 0; extra = 0; pr = 0; sa = 0; sb = 0;
    o2 = (o == 7'h33) ? b : im;
    sh = int'(o2[4:0]);
    if (o == 7'h37) r = im;
    else if (o == 7'h17) r = p + im;
    else if (o == 7'h33 && f7 == 7'h01) begin
`ifdef RISCV_EXEC_MUL_EN
      if (f3 >= 3'd4) il = 1;
      else begin
        sa = (f3 == 3'd1 || f3 == 3'd2) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (f3 == 3'd1) ? longint'($signed(b)) : longint'({32'b0, b});
        pr = 64'(sa * sb);
        r  = (f3 == 3'd0) ? pr[31:0] : pr[63:32];
      end
`else
      il = 1;
`endif
    end else if (o == 7'h33 || o == 7'h13) begin
      if (o == 7'h33 && f7 != 0 && !(f7 == 7'h20 && (f3 == 0 || f3 == 5))) il = 1;
      else begin
        case (f3)
          3'd0: r = (o == 7'h33 && f7 == 7'h20) ? a - o2 : a + o2;
          3'd1: if (f7 != 0) il = 1; else begin r = a << sh; extra = sh; end
          3'd2: r = ($signed(a) < $signed(o2)) ? 1 : 0;
          3'd3: r = (a < o2) ? 1 : 0;
          3'd4: r = a ^ o2;
          3'd5: begin
            if (f7 == 0) r = a >> sh;
            else if (f7 == 7'h20) r = $signed(a) >>> sh;
            else il = 1;
            extra = sh;
          end
          3'd6: r = a | o2;
          default: r = a & o2;
        endcase
      end
    end else il = 1;
    if (il) begin r = 0; extra = 0; end
    extra = extra * SER;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one op; returns at accept-edge + 1 time unit.
  task automatic send(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   extra;
    bit   acc;
    model(o, f3, f7, im, p, a, b, e.r, e.ill, extra);
    e.seen = 0;
    opcode = o; funct3 = f3; funct7 = f7; imm = im; pc = p; rs1 = a; rs2 = b;
    in_valid = 1;
    acc = 0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clock);
      if (in_ready) begin
        acc   = 1;
        e.due = cyc + 1 + extra;
        q.push_back(e);
      end
      step();
    end
    in_valid = 0;
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  // Pin the model to a hand-computed value, then run the op through the DUT.
  task automatic dir(input string nm, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] im, input logic [31:0] p, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic eil);
    logic [31:0] r;
    logic        il;
    int          x;
    model(o, f3, f7, im, p, a, b, r, il, x);
    chk({nm, "_model_rd"}, 64'(r), 64'(er));
    chk({nm, "_model_ill"}, 64'(il), 64'(eil));
    send(o, f3, f7, im, p, a, b);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Compare process: every cycle a result is presented it must match the
  // oldest outstanding op and appear exactly when that op is due.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!q[0].seen) begin
            chk("latency", 64'(cyc), 64'(q[0].due));
            q[0].seen = 1;
          end
          chk("rd", 64'(rd), 64'(q[0].r));
          chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int          lowcnt;
    logic [6:0]  o, f7;
    logic [2:0]  f3;
    logic [31:0] im, a, b, p, t;
    reset = 1; in_valid = 0; out_ready = 0;
    opcode = 0; funct3 = 0; funct7 = 0; imm = 0; pc = 0; rs1 = 0; rs2 = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    @(negedge clock);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_rd", 64'(rd), 64'd0);
    chk("reset_out_illegal", 64'(out_illegal), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    step();

    out_ready = 1;
    dir("add_wrap", OPC_OP, F3_ADD, F7_BASE, 0, 0, 32'h7FFF_FFFF, 1, 32'h8000_0000, 0);
    dir("sub", OPC_OP, F3_ADD, F7_ALT, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    dir("slt", OPC_OP, F3_SLT, F7_BASE, 0, 0, 32'hFFFF_FFFF, 1, 32'd1, 0);
    dir("sltu", OPC_OP, F3_SLTU, F7_BASE, 0, 0, 32'hFFFF_FFFF, 1, 32'd0, 0);
    dir("srai", OPC_OP_IMM, F3_SR, F7_ALT, 32'h0000_0404, 0, 32'h8000_0000, 0, 32'hF800_0000, 0);
    dir("slli0", OPC_OP_IMM, F3_SLL, F7_BASE, 32'h0, 0, 32'h1234_5678, 0, 32'h1234_5678, 0);
    dir("illegal_7f", 7'h7F, F3_ADD, F7_BASE, 32'h55, 0, 32'h1, 32'h2, 32'h0, 1);
    dir("addw_op32", 7'h3B, F3_ADD, F7_BASE, 0, 0, 32'h1, 32'h2, 32'h0, 1);
    dir("auipc_wrap", OPC_AUIPC, 0, 0, 32'hFFFF_F000, 32'h1000, 0, 0, 32'h0, 0);
    dir("lui", OPC_LUI, 0, 0, 32'hABCDE000, 0, 0, 0, 32'hABCD_E000, 0);
    dir("sub_imm_is_add", OPC_OP_IMM, F3_ADD, F7_ALT, 32'h0000_0400, 0, 32'h5, 0, 32'h405, 0);
    dir("sll_bad_f7", OPC_OP, F3_SLL, F7_ALT, 0, 0, 32'h1, 32'h1, 32'h0, 1);
`ifdef RISCV_EXEC_MUL_EN
    dir("mulh", OPC_OP, 3'b001, F7_MULDIV, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0);
    dir("mulhu", OPC_OP, 3'b011, F7_MULDIV, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    dir("div", OPC_OP, 3'b100, F7_MULDIV, 0, 0, 32'h6, 32'h3, 32'h0, 1);
`else
    dir("mul_disabled", OPC_OP, 3'b000, F7_MULDIV, 0, 0, 32'h6, 32'h3, 32'h0, 1);
`endif
    drain();

    // Serial SLL by 31: busy for 31 cycles, result on the 31st.
    dir("sll31", OPC_OP_IMM, F3_SLL, F7_BASE, 32'd31, 0, 32'h1, 0, 32'h8000_0000, 0);
    lowcnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (out_valid) break;
      if (!in_ready) lowcnt++;
    end
    chk("serial_in_ready_low_cycles", 64'(lowcnt), 64'd31);
    step();
    drain();

    // Reset part-way through a shift abandons it.
    send(OPC_OP_IMM, F3_SLL, F7_BASE, 32'd31, 0, 32'h1, 0);
    repeat (9) @(negedge clock);
    chk("mid_shift_in_ready", 64'(in_ready), 64'd0);
    step();
    reset = 1;
    q.delete();
    step();
    reset = 0;
    @(negedge clock);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clock);
    chk("post_reset_no_result", 64'(out_valid), 64'd0);
    step();

    // Backpressure, then retire-and-accept in the same cycle.
    out_ready = 0;
    send(OPC_OP, F3_ADD, F7_BASE, 0, 0, 32'd5, 32'd7);
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_rd_held", 64'(rd), 64'd12);
    end
    step();
    out_ready = 1;
    dir("nobubble_xor", OPC_OP, F3_XOR, F7_BASE, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    dir("nobubble_and", OPC_OP_IMM, F3_AND, F7_BASE, 32'h0000_00FF, 0, 32'h1234_5678, 0, 32'h78, 0);
    drain();

    // Randomised traffic with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: f7 = 7'h00;
        3:       f7 = 7'h20;
        4:       f7 = 7'h01;
        default: begin t = $urandom; f7 = t[6:0]; end
      endcase
      t  = $urandom;
      f3 = t[2:0];
      a  = rnd_val();
      b  = rnd_val();
      p  = $urandom;
      im = $urandom;
      case ($urandom_range(0, 9))
        0: o = OPC_LUI;
        1: o = OPC_AUIPC;
        2, 3, 4, 5: o = OPC_OP;
        6, 7, 8: o = OPC_OP_IMM;
        default: begin t = $urandom; o = t[6:0]; end
      endcase
      if (o == OPC_LUI || o == OPC_AUIPC) im = {im[31:12], 12'h000};
      else if (o == OPC_OP_IMM && (f3 == F3_SLL || f3 == F3_SR))
        im = {{20{f7[6]}}, f7, im[4:0]};
      else begin
        im = {{20{im[11]}}, im[11:0]};
        if (o == OPC_OP_IMM) f7 = im[11:5];
      end
      send(o, f3, f7, im, p, a, b);
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_ready = 0;
    step();
    out_ready = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
